spi_master_param: RTL and testbench

Parametrised, fully handshaked SPI master. It is the successor of the fixed 8-bit, divide-by-4 master. It adds configurable word width, a runtime clock divider, all four CPOL/CPHA modes with correct per-mode sample and shift edges, multiple chip selects, and a start/busy/done handshake. It sits between a local controller (CPU bus bridge or sequencer) and the board SPI pins.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_master_param_if.sv | 26 ++
 rtl/spi_sclk_gen.sv | 39 +++
 rtl/spi_master_param.sv | 128 ++++++++++++
 tb/tb_spi_master_param.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int unsigned cs_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Controller-side handshake bus of the SPI master.
interface spi_master_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned CS_W   = 2
);
  logic              start;
  logic              cpol;
  logic              cpha;
  logic [DIV_W-1:0]  clk_div;
  logic [CS_W-1:0]   cs_sel;
  logic [DATA_W-1:0] data_wr;
  logic [DATA_W-1:0] data_rd;
  logic              busy;
  logic              done;

  modport master (
    output start, cpol, cpha, clk_div, cs_sel, data_wr,
    input  data_rd, busy, done
  );

  modport slave (
    input  start, cpol, cpha, clk_div, cs_sel, data_wr,
    output data_rd, busy, done
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period divider and SCLK generator with leading/trailing edge strobes.
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             toggle,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cpol,
  output logic             spi_clk,
  output logic             tick_c,
  output logic             lead_edge_c,
  output logic             trail_edge_c
);

  logic [DIV_W-1:0] cnt;

  // Strobes fire on the same clk edge that moves spi_clk.
  assign tick_c       = enable && (cnt == clk_div);
  assign lead_edge_c  = tick_c && toggle && (spi_clk == cpol);
  assign trail_edge_c = tick_c && toggle && (spi_clk != cpol);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      spi_clk <= 1'b0;
    end else if (!enable) begin
      cnt     <= '0;
      spi_clk <= cpol;
    end else if (tick_c) begin
      cnt <= '0;
      if (toggle) spi_clk <= ~spi_clk;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: all four modes, runtime divider, multiple chip selects,
// start/busy/done handshake towards the local controller.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned CS_W   = cs_width(NUM_CS)
) (
  input  logic                clk,
  input  logic                reset,
  spi_master_param_if.slave   bus,
  output logic                spi_clk,
  output logic [NUM_CS-1:0]   cs_n,
  output logic                mosi,
  input  logic                miso
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state;
  logic              cpol_q;
  logic              cpha_q;
  logic [DIV_W-1:0]  clk_div_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BIT_W-1:0]  bit_cnt;
  logic              last_bit;

  logic gen_en_c, gen_toggle_c, gen_cpol_c;
  logic tick_c, lead_edge_c, trail_edge_c;
  logic sample_lead_c, sample_c, shift_c, xfer_end_c;
  logic [1:0] mode_c;

  assign gen_en_c     = (state != IDLE);
  assign gen_toggle_c = (state == XFER);
  // Idle level tracks the live input; during a transfer the latched copy.
  assign gen_cpol_c   = gen_en_c ? cpol_q : bus.cpol;

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk (
    .clk          (clk),
    .reset        (reset),
    .enable       (gen_en_c),
    .toggle       (gen_toggle_c),
    .clk_div      (clk_div_q),
    .cpol         (gen_cpol_c),
    .spi_clk      (spi_clk),
    .tick_c       (tick_c),
    .lead_edge_c  (lead_edge_c),
    .trail_edge_c (trail_edge_c)
  );

  assign mode_c        = {cpol_q, cpha_q};
  assign sample_lead_c = (mode_c == MODE0) || (mode_c == MODE2);
  assign sample_c      = sample_lead_c ? lead_edge_c : trail_edge_c;
  // cpha=0 holds the last bit through the final trailing edge.
  assign shift_c       = sample_lead_c ? (trail_edge_c && !last_bit)
                                       : (lead_edge_c && ((mode_c == MODE1) || (mode_c == MODE3)));
  assign xfer_end_c    = trail_edge_c &&
                         (sample_lead_c ? last_bit : (bit_cnt == BIT_W'(DATA_W - 1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      clk_div_q   <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      last_bit    <= 1'b0;
      cs_n        <= '1;
      mosi        <= 1'b0;
      bus.data_rd <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cpol_q    <= bus.cpol;
            cpha_q    <= bus.cpha;
            clk_div_q <= bus.clk_div;
            bit_cnt   <= '0;
            last_bit  <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= LEAD;
            if (32'(bus.cs_sel) < NUM_CS) cs_n <= ~(NUM_CS'(1) << bus.cs_sel);
            if (!bus.cpha) begin
              mosi  <= bus.data_wr[DATA_W-1];
              tx_sr <= {bus.data_wr[DATA_W-2:0], 1'b0};
            end else begin
              tx_sr <= bus.data_wr;
            end
          end
        end
        LEAD: begin
          if (tick_c) state <= XFER;
        end
        XFER: begin
          if (sample_c) begin
            rx_sr <= {rx_sr[DATA_W-2:0], miso};
            if (bit_cnt == BIT_W'(DATA_W - 1)) last_bit <= 1'b1;
            else                               bit_cnt  <= bit_cnt + BIT_W'(1);
          end
          if (shift_c) begin
            mosi  <= tx_sr[DATA_W-1];
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
          end
          if (xfer_end_c) state <= TRAIL;
        end
        TRAIL: begin
          if (tick_c) begin
            cs_n        <= '1;
            bus.data_rd <= rx_sr;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: vector table, random transfers, corner sequences.
module tb_spi_master_param;

  logic       clk;
  logic       reset;
  logic       spi_clk, mosi, miso;
  logic [3:0] cs_n;
  logic       spi_clk2, mosi2, miso2;
  logic [2:0] cs_n2;

  int checks;
  int failures;

  spi_master_param_if #(.DATA_W(8), .DIV_W(8), .CS_W(2)) bus ();
  spi_master_param_if #(.DATA_W(8), .DIV_W(8), .CS_W(2)) bus2 ();

  spi_master_param #(.DATA_W(8), .DIV_W(8), .NUM_CS(4), .CS_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master_param #(.DATA_W(8), .DIV_W(8), .NUM_CS(3), .CS_W(2)) dut3 (
    .clk(clk), .reset(reset), .bus(bus2),
    .spi_clk(spi_clk2), .cs_n(cs_n2), .mosi(mosi2), .miso(miso2)
  );

  assign miso2 = mosi2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0] mode;
    int         div;
    int         cs;
    logic [7:0] wr;
    logic [7:0] slv;
    bit         loop;
    logic [7:0] exp_rd;
    int         exp_done;
    bit         poke;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One transfer with a behavioural slave; expectations come from the mode rules.
  task automatic run_xfer(input string name, input logic [1:0] mode, input int div,
                          input int cs, input logic [7:0] wr, input logic [7:0] slv,
                          input bit loop, input logic [7:0] exp_rd, input int exp_done,
                          input bit keep_start, input bit poke);
    logic cpol_m, cpha_m, prev_clk, prev_mosi, lead;
    logic [7:0] rx_mosi;
    int n, sidx, toggles, rises, unstable, done_at;
    int cs_low [4];
    bit got_done;
    cpol_m = mode[1];
    cpha_m = mode[0];
    bus.cpol    = cpol_m;
    bus.cpha    = cpha_m;
    bus.clk_div = 8'(div);
    bus.cs_sel  = 2'(cs);
    bus.data_wr = wr;
    bus.start   = 1'b1;
    sidx = 0; toggles = 0; rises = 0; unstable = 0; rx_mosi = '0;
    for (int i = 0; i < 4; i++) cs_low[i] = 0;
    prev_clk  = cpol_m;
    prev_mosi = mosi;
    miso = loop ? mosi : (cpha_m ? 1'b0 : slv[7]);
    n = 0; got_done = 0; done_at = 0;
    while (!got_done && n < exp_done + 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (!keep_start) bus.start = 1'b0;
        chk({name, "_busy_c1"}, 32'(bus.busy), 32'd1);
        chk({name, "_idle_clk"}, 32'(spi_clk), 32'(cpol_m));
      end
      if (poke && (n == 5 || n == 20)) begin
        bus.start   = 1'b1;
        bus.data_wr = ~wr;
        bus.clk_div = 8'(div + 2);
        bus.cs_sel  = 2'(cs + 1);
      end
      if (poke && (n == 6 || n == 21)) bus.start = 1'b0;
      if (spi_clk != prev_clk) begin
        toggles++;
        if (spi_clk) rises++;
        lead = (spi_clk != cpol_m);
        if (lead != cpha_m) begin
          rx_mosi = {rx_mosi[6:0], mosi};
          if (mosi != prev_mosi) unstable++;
        end
        if (!loop) begin
          if (!cpha_m && !lead) begin
            sidx++;
            if (sidx < 8) miso = slv[7 - sidx];
          end else if (cpha_m && lead) begin
            if (sidx < 8) miso = slv[7 - sidx];
            sidx++;
          end
        end
      end
      if (loop) miso = mosi;
      for (int i = 0; i < 4; i++) if (!cs_n[i]) cs_low[i]++;
      prev_clk  = spi_clk;
      prev_mosi = mosi;
      if (bus.done) begin
        got_done = 1;
        done_at  = n;
      end
    end
    chk({name, "_done_seen"}, 32'(got_done), 32'd1);
    chk({name, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    chk({name, "_data_rd"}, 32'(bus.data_rd), 32'(exp_rd));
    chk({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({name, "_toggles"}, 32'(toggles), 32'd16);
    chk({name, "_rises"}, 32'(rises), 32'd8);
    chk({name, "_mosi_word"}, 32'(rx_mosi), 32'(wr));
    chk({name, "_mosi_stable"}, 32'(unstable), 32'd0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_cs%0d_low", name, i), 32'(cs_low[i]),
          (i == cs) ? 32'(exp_done - 1) : 32'd0);
    if (!keep_start) begin
      @(negedge clk);
      chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
      chk({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int n, cs_low3, done_at, dcount;
    logic [1:0] rmode;
    logic [7:0] rwr, rslv;
    int rdiv, rcs;
    bit rloop;
    checks = 0;
    failures = 0;

    vecs[0] = '{2'd0, 1, 0, 8'hA5, 8'h00, 1'b1, 8'hA5, 37, 1'b0};
    vecs[1] = '{2'd0, 3, 0, 8'h3C, 8'hC3, 1'b0, 8'hC3, 73, 1'b0};
    vecs[2] = '{2'd1, 3, 0, 8'h3C, 8'hC3, 1'b0, 8'hC3, 73, 1'b0};
    vecs[3] = '{2'd2, 3, 0, 8'h3C, 8'hC3, 1'b0, 8'hC3, 73, 1'b0};
    vecs[4] = '{2'd3, 3, 0, 8'h3C, 8'hC3, 1'b0, 8'hC3, 73, 1'b0};
    vecs[5] = '{2'd0, 0, 2, 8'h5A, 8'h96, 1'b0, 8'h96, 19, 1'b0};
    vecs[6] = '{2'd1, 2, 3, 8'hF0, 8'h0F, 1'b0, 8'h0F, 55, 1'b0};
    vecs[7] = '{2'd2, 1, 1, 8'hC3, 8'h00, 1'b1, 8'hC3, 37, 1'b1};

    reset = 1'b1;
    miso  = 1'b0;
    bus.start = 0; bus.cpol = 1; bus.cpha = 0; bus.clk_div = 0; bus.cs_sel = 0; bus.data_wr = 0;
    bus2.start = 0; bus2.cpol = 0; bus2.cpha = 0; bus2.clk_div = 0; bus2.cs_sel = 0; bus2.data_wr = 0;
    repeat (3) @(negedge clk);
    chk("rst_spi_clk", 32'(spi_clk), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_data_rd", 32'(bus.data_rd), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    #1 chk("rel_spi_clk_hold", 32'(spi_clk), 32'd0);
    @(negedge clk);
    chk("rel_spi_clk_cpol", 32'(spi_clk), 32'd1);

    for (int i = 0; i < 8; i++)
      run_xfer($sformatf("vec%0d", i), vecs[i].mode, vecs[i].div, vecs[i].cs, vecs[i].wr,
               vecs[i].slv, vecs[i].loop, vecs[i].exp_rd, vecs[i].exp_done, 1'b0, vecs[i].poke);

    for (int r = 0; r < 8; r++) begin
      rmode = 2'($urandom_range(3));
      rdiv  = int'($urandom_range(3));
      rcs   = int'($urandom_range(3));
      rwr   = 8'($urandom);
      rslv  = 8'($urandom);
      rloop = 1'($urandom_range(1));
      run_xfer($sformatf("rnd%0d", r), rmode, rdiv, rcs, rwr, rslv, rloop,
               rloop ? rwr : rslv, (2 * 8 + 2) * (rdiv + 1) + 1, 1'b0, 1'b0);
    end

    // Back-to-back: start held through the first done.
    run_xfer("b2b_1", 2'd0, 1, 0, 8'h01, 8'h00, 1'b1, 8'h01, 37, 1'b1, 1'b0);
    run_xfer("b2b_2", 2'd0, 1, 0, 8'h80, 8'h00, 1'b1, 8'h80, 37, 1'b0, 1'b0);

    // Reset in the middle of a transfer.
    bus.cpol = 0; bus.cpha = 0; bus.clk_div = 8'd1; bus.cs_sel = 2'd1; bus.data_wr = 8'h77;
    bus.start = 1'b1;
    for (n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
    end
    chk("mid_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_cs_n", 32'(cs_n), 32'hF);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_spi_clk", 32'(spi_clk), 32'd0);
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk("mid_rst_no_done", 32'(dcount), 32'd0);
    run_xfer("post_rst", 2'd3, 2, 1, 8'h96, 8'h69, 1'b0, 8'h69, 55, 1'b0, 1'b0);

    // Out-of-range chip select on the three-line instance.
    bus2.cpol = 0; bus2.cpha = 0; bus2.clk_div = 8'd0; bus2.cs_sel = 2'd3; bus2.data_wr = 8'hC9;
    bus2.start = 1'b1;
    cs_low3 = 0; done_at = 0;
    for (n = 1; n < 80 && done_at == 0; n++) begin
      @(negedge clk);
      if (n == 1) bus2.start = 1'b0;
      if (cs_n2 != 3'b111) cs_low3++;
      if (bus2.done) done_at = n;
    end
    chk("cs3_no_select", 32'(cs_low3), 32'd0);
    chk("cs3_done_cycle", 32'(done_at), 32'd19);
    chk("cs3_data_rd", 32'(bus2.data_rd), 32'hC9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
